// File: rtl/demux_2_16b_buf_pkg.sv
// Shared constants, slot state encoding and input payload type for the 1-to-4 word demux.
package demux_2_16b_buf_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned STAT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic              bcast;
        logic [SEL_W-1:0]  sel;
        logic [WIDTH-1:0]  data;
    } in_word_t;

endpackage

// File: rtl/demux_2_16b_buf_if.sv
// Input valid/ready port plus four output lanes and per-lane delivery counters.
interface demux_2_16b_buf_if import demux_2_16b_buf_pkg::*; ();

    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_bcast;
    logic [LANES-1:0]          out_valid;
    logic [LANES-1:0]          out_ready;
    logic [LANES*WIDTH-1:0]    out_data;
    logic [LANES*STAT_W-1:0]   stat_count;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, stat_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, stat_count
    );

endinterface

// File: rtl/demux_2_16b_buf_slot.sv
// Single-lane holding slot (demux_slot): one-entry register with drain logic.
// Optional per-lane drain counter built when DEMUX_STATS_EN is defined.
module demux_slot
    import demux_2_16b_buf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_ready,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output logic              accept_ok_c,
    output logic [STAT_W-1:0] count
);

    slot_state_t state, state_nxt;
    logic        drain_c;

    assign valid       = (state == FULL);
    assign drain_c     = valid && rd_ready;
    // A slot draining this cycle can take a new word in the same cycle.
    assign accept_ok_c = !valid || rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (wr_en) state_nxt = FULL;
            FULL:    if (drain_c && !wr_en) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Data is kept after a drain; only a write or reset changes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      data <= '0;
        else if (wr_en) data <= wr_data;
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        count <= '0;
        else if (drain_c) count <= count + STAT_W'(1);
    end
`else
    assign count = '0;
`endif

endmodule

// File: rtl/demux_2_16b_buf.sv
// Registered 1-to-4 demultiplexer for 16-bit words with unicast/broadcast steering.
// Optional per-lane drain counters: define DEMUX_STATS_EN.
module demux_2_16b_buf
    import demux_2_16b_buf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    demux_2_16b_buf_if.slave  bus
);

    in_word_t                 word;
    logic [LANES-1:0]         lane_ok_c;
    logic [LANES-1:0]         wr_en_c;
    logic [LANES-1:0]         lane_valid;
    logic [WIDTH-1:0]         lane_data [LANES];
    logic [STAT_W-1:0]        lane_cnt  [LANES];
    logic                     ready_c;
    logic                     accept_c;
    logic [LANES*WIDTH-1:0]   data_flat;
    logic [LANES*STAT_W-1:0]  cnt_flat;

    assign word = '{bcast: bus.in_bcast, sel: bus.in_sel, data: bus.in_data};

    // Broadcast waits until every lane can take the word; never a partial write.
    assign ready_c  = word.bcast ? (&lane_ok_c) : lane_ok_c[word.sel];
    assign accept_c = bus.in_valid && ready_c;

    always_comb begin
        wr_en_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            wr_en_c[i] = accept_c && (word.bcast || (word.sel == SEL_W'(i)));
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        demux_slot u_slot (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr_en_c[g]),
            .wr_data     (word.data),
            .rd_ready    (bus.out_ready[g]),
            .valid       (lane_valid[g]),
            .data        (lane_data[g]),
            .accept_ok_c (lane_ok_c[g]),
            .count       (lane_cnt[g])
        );
    end

    always_comb begin
        data_flat = '0;
        cnt_flat  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            data_flat[i*WIDTH +: WIDTH]   = lane_data[i];
            cnt_flat[i*STAT_W +: STAT_W]  = lane_cnt[i];
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_valid  = lane_valid;
    assign bus.out_data   = data_flat;
    assign bus.stat_count = cnt_flat;

endmodule

// File: tb/tb_demux_2_16b_buf.sv
// Directed bench for demux_2_16b_buf: vector table plus backpressure, streaming, reset and stats sequences.
module tb_demux_2_16b_buf;
    import demux_2_16b_buf_pkg::*;

`ifdef DEMUX_STATS_EN
    localparam logic [31:0] STAT_EXP = 32'h0000_0001;
`else
    localparam logic [31:0] STAT_EXP = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux_2_16b_buf_if ifc ();

    demux_2_16b_buf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        bc;
        logic [15:0] d;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_v;
        logic [63:0] exp_d;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic b,
                         input logic [15:0] d, input logic [3:0] r);
        ifc.in_valid  = v;
        ifc.in_sel    = s;
        ifc.in_bcast  = b;
        ifc.in_data   = d;
        ifc.out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] shifted;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 16'hACAC, 4'b0000, 1'b1, 4'b0100, 64'h0000_ACAC_0000_0000};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b0100, 64'h0000_ACAC_0000_0000};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 16'h1111, 4'b0000, 1'b1, 4'b0101, 64'h0000_ACAC_0000_1111};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 16'h2222, 4'b0000, 1'b0, 4'b0101, 64'h0000_ACAC_0000_1111};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 16'h2222, 4'b0001, 1'b1, 4'b0101, 64'h0000_ACAC_0000_2222};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b0101, 1'b1, 4'b0000, 64'h0000_ACAC_0000_2222};
        tbl[6]  = '{1'b1, 2'd0, 1'b1, 16'hBEEF, 4'b0000, 1'b1, 4'b1111, 64'hBEEF_BEEF_BEEF_BEEF};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 16'h1234, 4'b0111, 1'b0, 4'b1000, 64'hBEEF_BEEF_BEEF_BEEF};
        tbl[8]  = '{1'b1, 2'd0, 1'b1, 16'h1234, 4'b1000, 1'b1, 4'b1111, 64'h1234_1234_1234_1234};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 16'h5554, 4'b1101, 1'b0, 4'b0010, 64'h1234_1234_1234_1234};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 16'h0F0F, 4'b0000, 1'b1, 4'b1010, 64'h0F0F_1234_1234_1234};

        // Reset state, checked before any clock edge.
        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000);
        #2;
        chk("rst_valid", 64'(ifc.out_valid), 64'h0);
        chk("rst_data",  ifc.out_data, 64'h0);
        chk("rst_stat",  64'(ifc.stat_count), 64'h0);
        chk("rst_rdy_uni", 64'(ifc.in_ready), 64'h1);
        ifc.in_bcast = 1'b1;
        #1;
        chk("rst_rdy_bc", 64'(ifc.in_ready), 64'h1);
        ifc.in_bcast = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Vector table: unicast, stall, drain+write, broadcast gating.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].bc, tbl[i].d, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_rdy", i), 64'(ifc.in_ready), 64'(tbl[i].exp_rdy));
            step();
            chk($sformatf("vec%0d_valid", i), 64'(ifc.out_valid), 64'(tbl[i].exp_v));
            chk($sformatf("vec%0d_data", i), ifc.out_data, tbl[i].exp_d);
        end

        // Backpressure on lane 1, then simultaneous drain and write.
        drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111);
        step();
        chk("bp_empty", 64'(ifc.out_valid), 64'h0);
        drive(1'b1, 2'd1, 1'b0, 16'h5554, 4'b0000);
        step();
        chk("bp_fill", 64'(ifc.out_valid), 64'b0010);
        drive(1'b1, 2'd1, 1'b0, 16'hAAAA, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_rdy%0d", c), 64'(ifc.in_ready), 64'h0);
            step();
            chk($sformatf("bp_hold%0d", c), 64'(ifc.out_data[31:16]), 64'h5554);
        end
        ifc.out_ready = 4'b0010;
        #1;
        chk("bp_release_rdy", 64'(ifc.in_ready), 64'h1);
        step();
        chk("bp_release_valid", 64'(ifc.out_valid), 64'b0010);
        chk("bp_release_data", 64'(ifc.out_data[31:16]), 64'hAAAA);

        // Streaming with all lanes ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), 1'b0, 16'hC000 + 16'(i), 4'b1111);
            #1;
            chk($sformatf("str%0d_rdy", i), 64'(ifc.in_ready), 64'h1);
            step();
            chk($sformatf("str%0d_valid", i), 64'(ifc.out_valid), 64'(4'b0001 << (i % 4)));
            shifted = ifc.out_data >> (16 * (i % 4));
            chk($sformatf("str%0d_data", i), 64'(shifted[15:0]), 64'(16'hC000 + 16'(i)));
        end

        // Reset between edges with lanes 0, 1, 3 full.
        drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111);
        step();
        drive(1'b1, 2'd0, 1'b0, 16'h7001, 4'b0000);
        step();
        drive(1'b1, 2'd1, 1'b0, 16'h7002, 4'b0000);
        step();
        drive(1'b1, 2'd3, 1'b0, 16'h7004, 4'b0000);
        step();
        chk("mid_valid", 64'(ifc.out_valid), 64'b1011);
        ifc.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(ifc.out_valid), 64'h0);
        chk("mid_rst_data", ifc.out_data, 64'h0);
        chk("mid_rst_rdy_uni", 64'(ifc.in_ready), 64'h1);
        ifc.in_bcast = 1'b1;
        #1;
        chk("mid_rst_rdy_bc", 64'(ifc.in_ready), 64'h1);
        ifc.in_bcast = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_stat", 64'(ifc.stat_count), 64'h0);

        // 257 drains on lane 0; counter wraps to 1 when built.
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 2'd0, 1'b0, 16'(i), 4'b0001);
            step();
        end
        chk("stat_last_data", 64'(ifc.out_data[15:0]), 64'h0100);
        drive(1'b0, 2'd0, 1'b0, 16'h0000, 4'b0001);
        step();
        chk("stat_valid", 64'(ifc.out_valid), 64'h0);
        chk("stat_count", 64'(ifc.stat_count), 64'(STAT_EXP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
